// File: rtl/rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the round-robin arbiter slice.
//   - arb_state_e          : arbiter FSM states (idle / somebody owns the bus)
//   - ARB_N_DEFAULT        : default number of requesters
//   - ARB_QUANTUM_DEFAULT  : default maximum hold time while others wait
//   - arbOneHotToIndex()   : converts a one-hot grant vector into an owner index
// ---------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int ARB_N_DEFAULT       = 4;
  localparam int ARB_QUANTUM_DEFAULT = 8;

  // Returns the position of the set bit in a one-hot vector, or 0 when the
  // vector is all zeros. The vector is passed zero-extended to 32 bits so one
  // function serves every arbiter width up to 32 requesters.
  function automatic int unsigned arbOneHotToIndex(input logic [31:0] oneHot);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oneHot[i]) begin
        idx = i;
      end
    end
    return idx;
  endfunction

endpackage : arb_pkg

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority picker. Finds the first requester at or
// above ptr (wrapping modulo N) whose request is set and whose mask bit is
// clear.
//   req        in  N      request lines
//   ptr        in  IDW    highest-priority position for this search
//   mask       in  N      requesters excluded from this search
//   pick       out N      one-hot winner, or all zeros
//   pick_valid out 1      a winner exists
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic [N-1:0]   mask,
  output logic [N-1:0]   pick,
  output logic           pick_valid
);

  logic [N-1:0] eligible;

  assign eligible = req & ~mask;

  // Walk the N positions in priority order starting at ptr. The inner loop
  // maps the rotated position back onto a constant bit index so every vector
  // select stays static after unrolling.
  always_comb begin
    int pos;
    pick       = '0;
    pick_valid = 1'b0;
    pos        = 0;
    for (int i = 0; i < N; i++) begin
      pos = (int'(ptr) + i) % N;
      for (int j = 0; j < N; j++) begin
        if (j == pos && eligible[j] && !pick_valid) begin
          pick[j]    = 1'b1;
          pick_valid = 1'b1;
        end
      end
    end
  end

endmodule : rr_pick

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter sharing one resource among N requesters. An owner keeps
// the grant while it requests, for at most QUANTUM consecutive cycles when
// somebody else is waiting. Ownership passes to the next requester on the
// same edge the previous owner lets go, so there are no dead cycles.
//   clk     in  1        clock, rising edge
//   rst     in  1        synchronous active-high reset
//   req     in  N        level-sensitive requests
//   gnt     out N        registered one-hot grant, or all zeros
//   gnt_id  out IDW      registered owner index, 0 when idle
//   busy    out 1        OR of the grant flops
// ---------------------------------------------------------------------------
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N       = ARB_N_DEFAULT,
  parameter int QUANTUM = ARB_QUANTUM_DEFAULT,
  localparam int IDW    = (N > 1) ? $clog2(N) : 1,
  localparam int CW     = $clog2(QUANTUM + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy
);

  arb_state_e     state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [IDW-1:0] ptr_q,   ptr_d;
  logic [N-1:0]   gnt_q,   gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;

  logic [IDW-1:0] ownerNext;
  logic [IDW-1:0] searchPtr;
  logic [N-1:0]   searchMask;
  logic [N-1:0]   pick;
  logic           pickValid;
  logic           ownerReq;
  logic           othersReq;
  logic           expired;

  // Position just above the current owner, wrapping; this is where the
  // priority pointer lands whenever an owner finishes a turn.
  always_comb begin
    if (gnt_id_q == IDW'(N - 1)) begin
      ownerNext = '0;
    end else begin
      ownerNext = gnt_id_q + IDW'(1);
    end
  end

  // One picker serves both searches. While idle it starts at the stored
  // pointer with nothing masked; while granted it is set up for a possible
  // release, starting above the owner with the owner itself masked out.
  always_comb begin
    if (state_q == ARB_GRANT) begin
      searchPtr  = ownerNext;
      searchMask = gnt_q;
    end else begin
      searchPtr  = ptr_q;
      searchMask = '0;
    end
  end

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req        (req),
    .ptr        (searchPtr),
    .mask       (searchMask),
    .pick       (pick),
    .pick_valid (pickValid)
  );

  assign ownerReq  = |(req & gnt_q);
  assign othersReq = |(req & ~gnt_q);
  assign expired   = (count_q == CW'(QUANTUM));

  // Next-state logic. A grant continues while the owner requests and its
  // quantum is not used up; a lone owner at the quantum limit simply starts a
  // fresh quantum. Every other case in GRANT is a release, which either hands
  // straight over to the picker's winner or falls back to IDLE. A drop that
  // coincides with expiry lands in the release branch as well.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pickValid) begin
          gnt_d    = pick;
          gnt_id_d = IDW'(arbOneHotToIndex(32'(pick)));
          count_d  = CW'(1);
          state_d  = ARB_GRANT;
        end else begin
          gnt_d    = '0;
          gnt_id_d = '0;
        end
      end
      ARB_GRANT: begin
        if (ownerReq && !expired) begin
          count_d = count_q + CW'(1);
        end else if (ownerReq && !othersReq) begin
          count_d = CW'(1);
          ptr_d   = ownerNext;
        end else begin
          ptr_d = ownerNext;
          if (pickValid) begin
            gnt_d    = pick;
            gnt_id_d = IDW'(arbOneHotToIndex(32'(pick)));
            count_d  = CW'(1);
          end else begin
            gnt_d    = '0;
            gnt_id_d = '0;
            count_d  = '0;
            state_d  = ARB_IDLE;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and output registers. Reset wins over any request on the same edge,
  // so the first grant after reset always searches from requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      count_q  <= '0;
      ptr_q    <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = |gnt_q;

endmodule : rr_arbiter

// File: tb/tb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter
// Directed bench for rr_arbiter with N=4, QUANTUM=4. Each scenario task
// drives requests and compares the registered outputs one time unit after
// the rising edge against hand-derived values.
// ---------------------------------------------------------------------------
module tb_rr_arbiter;

  localparam int N       = 4;
  localparam int QUANTUM = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [1:0]   gntId;
  logic         busy;

  int checks;
  int failures;

  rr_arbiter #(
    .N       (N),
    .QUANTUM (QUANTUM)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gntId),
    .busy   (busy)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Return the arbiter to a clean idle state with nothing requesting.
  task automatic doReset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reset holds everything at zero even with all requests up, then the first
  // free edge grants requester 0. Idle with no requests stays idle.
  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    tick();
    tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || gntId !== 2'd0) begin
      failures++;
      $display("[TB] FAIL reset_hold: gnt=%b busy=%b id=%0d, need gnt=0000 busy=0 id=0", gnt, busy, gntId);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1 || gntId !== 2'd0) begin
      failures++;
      $display("[TB] FAIL reset_first_grant: gnt=%b busy=%b id=%0d, need gnt=0001 busy=1 id=0", gnt, busy, gntId);
    end
    doReset();
    tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_no_req: gnt=%b busy=%b, need gnt=0000 busy=0", gnt, busy);
    end
  endtask

  // A lone requester keeps the grant straight through quantum boundaries.
  task automatic test_single();
    doReset();
    req = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0100 || gntId !== 2'd2 || busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL single cycle %0d: gnt=%b id=%0d busy=%b, need gnt=0100 id=2 busy=1", c, gnt, gntId, busy);
      end
    end
  endtask

  // Everyone requesting: each owner gets exactly QUANTUM cycles in turn.
  task automatic test_full_load();
    logic [N-1:0] expGnt;
    logic [1:0]   expId;
    doReset();
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      tick();
      expId  = 2'((c / QUANTUM) % N);
      expGnt = 4'b0001 << expId;
      checks++;
      if (gnt !== expGnt || gntId !== expId || busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL full_load cycle %0d: gnt=%b id=%0d busy=%b, need gnt=%b id=%0d busy=1", c, gnt, gntId, busy, expGnt, expId);
      end
    end
  endtask

  // Owner drops early: next requester takes over on the very next edge, and
  // dropping everything returns to idle one edge later.
  task automatic test_early_release();
    doReset();
    req = 4'b0011;
    tick();
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL early_owner0: gnt=%b, need 0001", gnt);
    end
    req = 4'b0010;
    tick();
    checks++;
    if (gnt !== 4'b0010 || gntId !== 2'd1 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL early_handover: gnt=%b id=%0d busy=%b, need gnt=0010 id=1 busy=1", gnt, gntId, busy);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || gntId !== 2'd0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL early_idle: gnt=%b id=%0d busy=%b, need gnt=0000 id=0 busy=0", gnt, gntId, busy);
    end
  endtask

  // Owner 1 drops on the edge its quantum expires with 0 and 3 waiting: the
  // search starts at 2, so 3 wins; after 3's quantum the turn wraps to 0.
  task automatic test_drop_expiry();
    doReset();
    req = 4'b0010;
    for (int c = 0; c < QUANTUM; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0010) begin
        failures++;
        $display("[TB] FAIL drop_expiry_hold cycle %0d: gnt=%b, need 0010", c, gnt);
      end
    end
    req = 4'b1001;
    tick();
    checks++;
    if (gnt !== 4'b1000 || gntId !== 2'd3) begin
      failures++;
      $display("[TB] FAIL drop_expiry_pick: gnt=%b id=%0d, need gnt=1000 id=3", gnt, gntId);
    end
    for (int c = 1; c < QUANTUM; c++) tick();
    checks++;
    if (gnt !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL drop_expiry_q3: gnt=%b, need 1000", gnt);
    end
    tick();
    checks++;
    if (gnt !== 4'b0001 || gntId !== 2'd0) begin
      failures++;
      $display("[TB] FAIL drop_expiry_wrap: gnt=%b id=%0d, need gnt=0001 id=0", gnt, gntId);
    end
  endtask

  // Reset in the middle of a grant clears outputs and the pointer.
  task automatic test_mid_reset();
    doReset();
    req = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0100) begin
      failures++;
      $display("[TB] FAIL mid_reset_pre: gnt=%b, need 0100", gnt);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0000 || gntId !== 2'd0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset_clear: gnt=%b id=%0d busy=%b, need gnt=0000 id=0 busy=0", gnt, gntId, busy);
    end
    rst = 1'b0;
    req = 4'b1100;
    tick();
    checks++;
    if (gnt !== 4'b0100 || gntId !== 2'd2 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_reset_regrant: gnt=%b id=%0d busy=%b, need gnt=0100 id=2 busy=1", gnt, gntId, busy);
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req      = '0;
    test_reset();
    test_single();
    test_full_load();
    test_early_release();
    test_drop_expiry();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rr_arbiter

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter that shares one resource among `N` requesters, one owner at a time. Each requester drives a request line. The arbiter returns a registered one-hot grant, the owner's index, and a `busy` flag that is the OR of all grant bits. A grant is held while the owner keeps requesting, up to a quantum of `QUANTUM` cycles. The block sits in front of any shared gate-level datapath so that only the granted requester drives it.

## Interface
- `N`, 4: number of requesters; at least 2.
- `QUANTUM`, 8: maximum consecutive cycles one owner may hold the grant while others wait; at least 1.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N  request per requester; level-sensitive.
- `gnt`  out  N  one-hot grant, or all zeros; registered.
- `gnt_id`  out  $clog2(N)  index of the current owner; 0 when idle; registered.
- `busy`  out  1  OR-reduction of `gnt`.

## Operation
- Reset (`rst`=1 at an edge): `gnt`=0, `gnt_id`=0, `busy`=0, priority pointer `ptr`=0, `count`=0, state IDLE.
- State IDLE:
  - If `req`≠0, grant the first requester at or above `ptr`, wrapping modulo N.
  - Set `count`=1 and go to GRANT.
  - Otherwise stay in IDLE with `gnt`=0.
- State GRANT, owner `o`:
  - `req[o]`=1 and `count`<QUANTUM: hold the grant and increment `count`.
  - `req[o]`=0: release.
  - `count`==QUANTUM and some other `req` bit is set: release.
  - `count`==QUANTUM and `req[o]` is the only request: re-grant `o` with `count`=1. Keep `ptr`=o+1 mod N.
- On release:
  - Set `ptr`=o+1 mod N.
  - Search `req` with `req[o]` masked, starting at the new `ptr`.
  - Hit: grant that requester on the same edge with `count`=1 and stay in GRANT. There is no idle cycle between owners.
  - Miss: `gnt`=0 and go to IDLE.
- Simultaneous owner drop and quantum expiry: treat as a release by drop. The result is identical.
- A released owner is masked only for the handover edge. Afterwards it competes normally at lowest round-robin priority.
- Invariants: `gnt` is never multi-hot. `busy`==|`gnt` in every cycle. `count` never exceeds QUANTUM. `count` width is $clog2(QUANTUM+1).

## Timing
- Latency: `req` sampled at edge k; `gnt`, `gnt_id` and `busy` update after edge k. The first grant appears 1 cycle after the request.
- Handover: the owner deasserts `req` before edge k, and the next owner's `gnt` is high after edge k. Zero dead cycles.
- Maximum wait for a requester that stays asserted: (N−1)·QUANTUM cycles after its first sampled edge.
- `rst` mid-grant: all outputs are 0 after that edge, whatever `req` is. The first grant comes on the first edge with `rst`=0, searching from `ptr`=0.
- All outputs are driven from flops or from a pure OR of flops. No combinational path from `req` to any output.

## Structure
- Package `arb_pkg` holds:
  - the state enum (`ARB_IDLE`, `ARB_GRANT`);
  - default `N` and `QUANTUM` localparams;
  - a one-hot-to-index function used for `gnt_id`.
- Sub-module `rr_pick`: combinational rotating-priority picker. Inputs are `req` (N), `ptr` and a `mask` (N). Outputs are a one-hot `pick` and `pick_valid`. Instantiate it once and use it for both the IDLE search and the release search.
- `rr_arbiter` holds the FSM, `count`, `ptr` and the output registers.

## Test plan
All scenarios use N=4, QUANTUM=4.
- Reset: `rst`=1 for 2 edges with `req`=1111 -> `gnt`=0000, `busy`=0. After the first edge with `rst`=0 -> `gnt`=0001, `gnt_id`=0, `busy`=1.
- Single requester: `req`=0100 held for 10 cycles -> `gnt`=0100, `gnt_id`=2 continuously, with no gap at the quantum boundaries.
- Full load: `req`=1111 constant -> `gnt` gives 0001 for 4 cycles, then 0010 ×4, 0100 ×4, 1000 ×4, then 0001 again. `busy` never drops.
- Early release: `req`=0011 with `gnt`=0001; `req[0]` drops after 2 granted cycles -> `gnt`=0010 on the next edge with no idle cycle. Then `req`=0000 -> `gnt`=0000 and `busy`=0 one edge later.
- Simultaneous drop and expiry: owner 1 at `count`=4 drops `req[1]` on the same edge, with `req`=1001 pending -> `gnt`=1000 (`ptr`=2 search finds requester 3 first).
- Mid-grant reset: `gnt`=0100, then `rst`=1 for one edge -> `gnt`=0000. Release `rst` with `req`=1100 -> `gnt`=0100 (`ptr` was reset to 0).
